// File: rtl/ad_clk_div_gen.sv
// Two runtime-programmable 50%-duty clock dividers plus a glitch-safe select
// line for the downstream ADC clock mux (ad_clk_fin = sel ? clk_1 : clk_2).
module ad_clk_div_gen #(
  parameter int   CNT_W    = 16,
  parameter int   DIV1_RST = 2,
  parameter int   DIV2_RST = 50,
  parameter logic SEL_RST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] div1_half,
  input  logic [CNT_W-1:0] div2_half,
  input  logic             cfg_load,
  input  logic             sel_req,
  output logic             clk_1,
  output logic             clk_2,
  output logic             sel,
  output logic             cfg_busy,
  output logic             sel_busy
);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, SWITCH, HOLD} state_t;

  localparam logic [CNT_W-1:0] H1_RST = CNT_W'(DIV1_RST);
  localparam logic [CNT_W-1:0] H2_RST = CNT_W'(DIV2_RST);

  logic [CNT_W-1:0] cnt1, cnt2;
  logic [CNT_W-1:0] half1, half2;
  logic [CNT_W-1:0] shad1, shad2;
  logic [CNT_W-1:0] lim1, lim2;
  logic             pend1, pend2;
  logic             pend1_nxt, pend2_nxt;
  logic             wrap1, wrap2;
  logic             fall1, fall2;
  logic             clk1_nxt, clk2_nxt;
  state_t           state;
  logic             hold_cnt;

  // A half-period of zero behaves like one, so the wrap limit saturates at zero.
  always_comb begin
    lim1      = (half1 == '0) ? '0 : half1 - CNT_W'(1);
    lim2      = (half2 == '0) ? '0 : half2 - CNT_W'(1);
    wrap1     = (cnt1 == lim1);
    wrap2     = (cnt2 == lim2);
    clk1_nxt  = wrap1 ? ~clk_1 : clk_1;
    clk2_nxt  = wrap2 ? ~clk_2 : clk_2;
    fall1     = wrap1 & clk_1;
    fall2     = wrap2 & clk_2;
    pend1_nxt = cfg_load | (pend1 & ~fall1);
    pend2_nxt = cfg_load | (pend2 & ~fall2);
  end

  // Shadow divisors only take effect on a 1->0 edge so every period stays whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1     <= '0;
      cnt2     <= '0;
      clk_1    <= 1'b0;
      clk_2    <= 1'b0;
      half1    <= H1_RST;
      half2    <= H2_RST;
      shad1    <= H1_RST;
      shad2    <= H2_RST;
      pend1    <= 1'b0;
      pend2    <= 1'b0;
      cfg_busy <= 1'b0;
    end else begin
      cnt1     <= wrap1 ? '0 : cnt1 + CNT_W'(1);
      cnt2     <= wrap2 ? '0 : cnt2 + CNT_W'(1);
      clk_1    <= clk1_nxt;
      clk_2    <= clk2_nxt;
      if (fall1 && pend1) half1 <= shad1;
      if (fall2 && pend2) half2 <= shad2;
      if (cfg_load) begin
        shad1 <= div1_half;
        shad2 <= div2_half;
      end
      pend1    <= pend1_nxt;
      pend2    <= pend2_nxt;
      cfg_busy <= pend1_nxt | pend2_nxt;
    end
  end

  // sel may only move on an edge where both registered clocks are low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= 1'b0;
      sel      <= SEL_RST;
      sel_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_req != sel) begin
            state    <= WAIT_LOW;
            sel_busy <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (sel_req == sel) begin
            state    <= IDLE;
            sel_busy <= 1'b0;
          end else if (!clk1_nxt && !clk2_nxt) begin
            state <= SWITCH;
          end
        end
        SWITCH: begin
          sel      <= sel_req;
          state    <= HOLD;
          hold_cnt <= 1'b0;
        end
        HOLD: begin
          if (hold_cnt) begin
            state    <= IDLE;
            sel_busy <= 1'b0;
          end else begin
            hold_cnt <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          sel_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
